word_serializer: RTL and testbench

Parametrised, sequential successor to the combinational word-to-byte splitter. It accepts a DATA_W-bit word over a valid/ready handshake, slices it into LANE_W-bit lanes, and emits one lane per cycle over a second valid/ready handshake. Lane order (MSB-first or LSB-first) and the number of lanes sent are chosen per word. It sits between a word-wide producer (register file / bus read path) and a narrow consumer such as a byte-wide memory port or UART staging.

---
 rtl/word_serializer_pkg.sv | 17 +
 rtl/word_serializer_if.sv | 27 ++
 rtl/word_serializer_lane_select.sv | 23 ++
 rtl/word_serializer.sv | 96 +++++++++
 tb/tb_word_serializer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/word_serializer_pkg.sv
// Shared types and constants for the word-to-lane serializer.
package word_serializer_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_LANE_W = 8;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_e;

  // Lane index/count width; a single-lane configuration still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned n_lanes);
    return (n_lanes > 1) ? $clog2(n_lanes) : 1;
  endfunction

endpackage

// File: rtl/word_serializer_if.sv
// Word-in / lane-out handshake bundle; master is the producer+consumer side, slave is the serializer.
interface word_serializer_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANE_W = 8,
  parameter int unsigned CNT_W  = 2
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_msb_first;
  logic [CNT_W-1:0]  in_lanes;
  logic              out_valid;
  logic              out_ready;
  logic [LANE_W-1:0] out_data;
  logic [CNT_W-1:0]  out_idx;
  logic              out_last;

  modport master (
    output in_valid, in_data, in_msb_first, in_lanes, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_data, in_msb_first, in_lanes, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/word_serializer_lane_select.sv
// Combinational lane picker: returns lane idx of word, counted from the MSB or LSB end.
module lane_select #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANE_W = 8,
  parameter int unsigned CNT_W  = 2
) (
  input  logic [DATA_W-1:0] word,
  input  logic [CNT_W-1:0]  idx,
  input  logic              msb_first,
  output logic [LANE_W-1:0] lane
);
  localparam int unsigned N_LANES = DATA_W / LANE_W;

  always_comb begin
    lane = '0;
    for (int unsigned k = 0; k < N_LANES; k++) begin
      if (idx == CNT_W'(k)) begin
        lane = msb_first ? word[DATA_W-1-k*LANE_W -: LANE_W]
                         : word[k*LANE_W +: LANE_W];
      end
    end
  end
endmodule

// File: rtl/word_serializer.sv
// Accepts a word, then emits its lanes one per cycle in the order and count sampled at accept.
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned LANE_W = DEF_LANE_W
) (
  input logic               clk,
  input logic               reset,
  word_serializer_if.slave  bus
);
  localparam int unsigned N_LANES = DATA_W / LANE_W;
  localparam int unsigned CNT_W   = cnt_width(N_LANES);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              msb_q, msb_d;
  logic [CNT_W-1:0]  lanes_q, lanes_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              sending;
  logic              last;
  logic              fire;
  logic              accept;
  logic [CNT_W-1:0]  lanes_in;
  logic [LANE_W-1:0] lane;

  // Out-of-range lane counts only exist when N_LANES is not a power of two.
  if ((1 << CNT_W) == N_LANES) begin : g_pow2
    assign lanes_in = bus.in_lanes;
  end else begin : g_clamp
    assign lanes_in = (bus.in_lanes > CNT_W'(N_LANES - 1)) ? CNT_W'(N_LANES - 1)
                                                            : bus.in_lanes;
  end

  lane_select #(
    .DATA_W (DATA_W),
    .LANE_W (LANE_W),
    .CNT_W  (CNT_W)
  ) u_lane_select (
    .word      (word_q),
    .idx       (cnt_q),
    .msb_first (msb_q),
    .lane      (lane)
  );

  assign sending = (state_q == ST_SEND);
  assign last    = sending && (cnt_q == lanes_q);
  assign fire    = sending && bus.out_ready;

  // Ready reopens on the final-lane transfer so a waiting word loads without a bubble.
  assign bus.in_ready  = !sending || (fire && last);
  assign accept        = bus.in_valid && bus.in_ready;

  assign bus.out_valid = sending;
  assign bus.out_data  = lane;
  assign bus.out_idx   = sending ? cnt_q : '0;
  assign bus.out_last  = last;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    msb_d   = msb_q;
    lanes_d = lanes_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = ST_SEND;
      word_d  = bus.in_data;
      msb_d   = bus.in_msb_first;
      lanes_d = lanes_in;
      cnt_d   = '0;
    end else if (fire) begin
      if (last) begin
        state_d = ST_IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      msb_q   <= 1'b0;
      lanes_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      msb_q   <= msb_d;
      lanes_q <= lanes_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_word_serializer.sv
// Randomized bench for word_serializer against a lane-queue reference model; also a 64/16 instance.
module tb_word_serializer;
  import word_serializer_pkg::*;

  logic clk;
  logic reset;
  int unsigned errors;
  int unsigned checks;

  word_serializer_if #(.DATA_W(32), .LANE_W(8),  .CNT_W(cnt_width(4))) a_if ();
  word_serializer_if #(.DATA_W(64), .LANE_W(16), .CNT_W(cnt_width(4))) b_if ();

  word_serializer #(.DATA_W(32), .LANE_W(8)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (a_if)
  );

  word_serializer #(.DATA_W(64), .LANE_W(16)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    int unsigned idx;
    bit          last;
  } exp_t;

  exp_t exp_q[$];
  bit   acc_seen;
  bit   rdy_rand;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_lane32(input logic [31:0] w, input bit msb, input int k);
    int sh;
    sh = msb ? (32 - 8 * (k + 1)) : (8 * k);
    return 8'((w >> sh) & 32'hFF);
  endfunction

  function automatic logic [15:0] ref_lane64(input logic [63:0] w, input bit msb, input int k);
    int sh;
    sh = msb ? (64 - 16 * (k + 1)) : (16 * k);
    return 16'((w >> sh) & 64'hFFFF);
  endfunction

  // One clock of instance A: check outputs against the model, then advance the model over the edge.
  task automatic cycle();
    bit exp_rdy;
    bit acc;
    bit fire;
    @(negedge clk);
    check("out_valid", a_if.out_valid, exp_q.size() != 0);
    exp_rdy = (exp_q.size() == 0) || (a_if.out_ready && exp_q.size() == 1);
    check("in_ready", a_if.in_ready, exp_rdy);
    if (exp_q.size() != 0) begin
      check("out_data", a_if.out_data, exp_q[0].data);
      check("out_idx",  a_if.out_idx,  exp_q[0].idx);
      check("out_last", a_if.out_last, exp_q[0].last);
    end
    acc  = a_if.in_valid && exp_rdy;
    fire = (exp_q.size() != 0) && a_if.out_ready;
    if (fire) void'(exp_q.pop_front());
    if (acc) begin
      acc_seen = 1'b1;
      for (int k = 0; k <= int'(a_if.in_lanes); k++) begin
        exp_t e;
        e.data = ref_lane32(a_if.in_data, a_if.in_msb_first, k);
        e.idx  = k;
        e.last = (k == int'(a_if.in_lanes));
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    if (rdy_rand) a_if.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_word(input logic [31:0] data, input bit msb, input logic [1:0] lanes);
    a_if.in_valid     = 1'b1;
    a_if.in_data      = data;
    a_if.in_msb_first = msb;
    a_if.in_lanes     = lanes;
    acc_seen = 1'b0;
    for (int n = 0; n < 64 && !acc_seen; n++) cycle();
    if (!acc_seen) check("accept_timeout", 64'd0, 64'd1);
    // Scramble the inputs: the word in flight must not notice.
    a_if.in_valid     = 1'b0;
    a_if.in_data      = $urandom;
    a_if.in_msb_first = 1'($urandom);
    a_if.in_lanes     = 2'($urandom);
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) cycle();
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_b(input logic [63:0] w, input bit msb, input logic [1:0] lanes);
    b_if.in_valid     = 1'b1;
    b_if.in_data      = w;
    b_if.in_msb_first = msb;
    b_if.in_lanes     = lanes;
    b_if.out_ready    = 1'b1;
    @(negedge clk);
    check("b_in_ready", b_if.in_ready, 64'd1);
    @(posedge clk);
    #1;
    b_if.in_valid = 1'b0;
    b_if.in_data  = '1;
    for (int k = 0; k <= int'(lanes); k++) begin
      @(negedge clk);
      check("b_out_valid", b_if.out_valid, 64'd1);
      check("b_out_data",  b_if.out_data,  ref_lane64(w, msb, k));
      check("b_out_idx",   b_if.out_idx,   64'(k));
      check("b_out_last",  b_if.out_last,  64'(k == int'(lanes)));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("b_idle", b_if.out_valid, 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    errors   = 0;
    checks   = 0;
    rdy_rand = 1'b0;
    reset    = 1'b1;
    a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.in_msb_first = 1'b0;
    a_if.in_lanes = '0;   a_if.out_ready = 1'b1;
    b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.in_msb_first = 1'b0;
    b_if.in_lanes = '0;   b_if.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", a_if.out_valid, 64'd0);
    check("rst_out_data",  a_if.out_data,  64'd0);
    check("rst_out_idx",   a_if.out_idx,   64'd0);
    check("rst_out_last",  a_if.out_last,  64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready", a_if.in_ready, 64'd1);

    // MSB-first then LSB-first full words
    send_word(32'h12345678, 1'b1, 2'd3);
    drain();
    send_word(32'h12345678, 1'b0, 2'd3);
    drain();

    // Backpressure while lane 1 is shown
    send_word(32'h12345678, 1'b1, 2'd3);
    cycle();
    a_if.out_ready = 1'b0;
    repeat (3) cycle();
    a_if.out_ready = 1'b1;
    drain();

    // Partial word followed by a back-to-back full word
    send_word(32'hAABBCCDD, 1'b1, 2'd1);
    send_word(32'h01020304, 1'b1, 2'd3);
    drain();

    // Asynchronous reset after lane 2 has been transferred
    send_word(32'h12345678, 1'b1, 2'd3);
    repeat (3) cycle();
    #2;
    reset = 1'b1;
    #1;
    check("arst_out_valid", a_if.out_valid, 64'd0);
    check("arst_out_idx",   a_if.out_idx,   64'd0);
    check("arst_out_last",  a_if.out_last,  64'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    send_word(32'hCAFEF00D, 1'b0, 2'd2);
    drain();

    // Wide-lane instance
    run_b(64'h0011223344556677, 1'b1, 2'd3);
    run_b({$urandom, $urandom}, 1'b0, 2'($urandom));

    // Randomized traffic with random backpressure and input gaps
    rdy_rand = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send_word($urandom, 1'($urandom), 2'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) cycle();
      end
    end
    a_if.out_ready = 1'b1;
    rdy_rand = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
